fraction_multiplier_seq: RTL
============================

Name: fraction_multiplier_seq

Overview:
Iterative unsigned radix-4 fraction multiplier. It is the multiplicative counterpart of the Goldschmidt divider in the FPU datapath and uses the same start/busy/ready handshake and the same operand format (.1xxx...x fractions). It produces the full double-width product, plus a normalized upper word with shift and sticky flags for the FP multiply path.

Parameters:
WIDTH, 32, operand width in bits; must be even and >= 4
ITER, WIDTH/2, iteration count (radix-4 digits); derived, not overridden

Ports:
clk  input  1  clock, rising edge
clrn  input  1  asynchronous active-low reset
start  input  1  load operands and begin; sampled every rising edge
a  input  WIDTH  multiplicand fraction .xxx...x
b  input  WIDTH  multiplier fraction .xxx...x
p  output  2*WIDTH  raw product 0.xxx...x; valid while ready=1
pn  output  WIDTH  normalized product: p[2W-1] ? p[2W-1:W] : p[2W-2:W-1]
sh  output  1  1 when normalization shifted left by one (~p[2W-1])
sticky  output  1  OR of all p bits below those selected into pn
busy  output  1  iteration in progress
ready  output  1  result valid, held until next start

Behaviour:
- Reset: clk is the clock; clrn is the reset, asynchronous and active-low. Reset clears all state: busy=0, ready=0, p=0, internal counter=0.
- State: IDLE (busy=0) and RUN (busy=1). ready is a separate registered flag.
- start=1 at a rising edge, from any state including RUN:
  - load A=a, A3=3*a (WIDTH+2 bits), product register P={(WIDTH+2) zeros, b}.
  - set count=0, busy=1, ready=0.
  - start always wins; an in-flight operation is aborted with no result.
- Each RUN edge with start=0:
  - d=P[1:0]; select pp from {0, A, 2A, A3} by d.
  - P <= {P_hi + pp, P_lo} >> 2, with the upper sum kept at WIDTH+2 bits (no loss).
  - count <= count+1.
- On the edge where count==ITER-1: the final shift is taken, busy<=0, ready<=1. The counter width is clog2(ITER).
- Latency: ready rises exactly ITER edges after the edge that sampled start (16 for WIDTH=32). busy is high for exactly ITER cycles.
- start held high for N cycles: the operation reloads every cycle. ready rises ITER edges after the last start edge.
- IDLE with start=0: P, ready, busy hold. The result remains stable indefinitely.
- p = P[2W-1:0], registered. pn, sh and sticky are combinational from p.
  - For normalized inputs (MSB=1), p >= 0.25, so p[2W-1]|p[2W-2]=1.
  - For zero or unnormalized inputs, pn/sh are still computed by the formula with no special-casing.
- Arithmetic is unsigned and truncating; no rounding inside the block. Rounding is the consumer's job, using sticky.
- Reset asserted mid-RUN: immediate abort to the reset values. After clrn deasserts, the block ignores everything until start.
- Operands a and b are only sampled on start edges; changes during RUN have no effect.

Decomposition:
- Shared FPU package:
  - FRAC_W=32 default.
  - function or constant for ITER and the counter width.
  - Booth-free radix-4 digit encoding constants (DIG_0..DIG_3).
- One natural sub-module: mul_radix4_pp_sel, a combinational 4:1 select of {0, A, 2A, A3} by digit.
  - Instantiated once; keeps the datapath mux out of the control block.
- Control (counter, busy, ready) and the P register live in the top module.

Test Plan:
1. clrn low, then release with start=0 for 20 cycles -> busy=0, ready=0, p=0 throughout.
2. a=b=0x80000000, start for 1 cycle ->
   - busy=1 for 16 cycles; ready rises on the 16th edge after start.
   - p=0x4000000000000000, pn=0x80000000, sh=1, sticky=0.
3. a=b=0xFFFFFFFF -> p=0xFFFFFFFE00000001, pn=0xFFFFFFFE, sh=0, sticky=1. Then a=0xC0000000, b=0x80000000 -> p=0x6000000000000000, pn=0xC0000000, sh=1, sticky=0.
4. Restart: start a=b=0xFFFFFFFF, then at cycle 7 of RUN start a=0xC0000000, b=0xC0000000 ->
   - no ready in between.
   - ready 16 edges after the second start; p=0x9000000000000000, sh=0.
5. clrn pulsed low at cycle 5 of RUN -> busy=0, ready=0, p=0 asynchronously. No ready is produced until a new start.
6. start held high 3 cycles with a=0, b=0x80000000 -> ready 16 edges after the last start; p=0, pn=0, sh=1, sticky=0. The result then holds for 50 idle cycles.

Source files
------------

// File: rtl/fraction_multiplier_seq_pkg.sv
// Shared FPU fraction-datapath definitions.
//   FRAC_W         default fraction width
//   iter_of()      radix-4 iteration count for a given width
//   cnt_w_of()     counter width for a given iteration count
//   DIG_0..DIG_3   radix-4 multiplier digit encodings (no Booth recoding)
//   state_e        iterative-unit control state
package fraction_multiplier_seq_pkg;

  localparam int FRAC_W = 32;

  localparam logic [1:0] DIG_0 = 2'd0;
  localparam logic [1:0] DIG_1 = 2'd1;
  localparam logic [1:0] DIG_2 = 2'd2;
  localparam logic [1:0] DIG_3 = 2'd3;

  function automatic int iter_of(input int w);
    return w / 2;
  endfunction

  function automatic int cnt_w_of(input int iter);
    return (iter > 1) ? $clog2(iter) : 1;
  endfunction

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

endpackage

// File: rtl/fraction_multiplier_seq_pp_sel.sv
// Radix-4 partial-product select.
//   a    multiplicand (WIDTH)
//   a3   precomputed 3*a (WIDTH+2)
//   dig  current multiplier digit
//   pp   selected partial product {0, a, 2a, 3a} (WIDTH+2)
module mul_radix4_pp_sel
  import fraction_multiplier_seq_pkg::*;
#(
  parameter int WIDTH = FRAC_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH+1:0] a3,
  input  logic [1:0]       dig,
  output logic [WIDTH+1:0] pp
);

  always_comb begin
    pp = '0;
    case (dig)
      DIG_0:   pp = '0;
      DIG_1:   pp = {2'b00, a};
      DIG_2:   pp = {1'b0, a, 1'b0};
      default: pp = a3;
    endcase
  end

endmodule

// File: rtl/fraction_multiplier_seq.sv
// Iterative unsigned radix-4 fraction multiplier (two multiplier bits per cycle).
//   clk, clrn   clock / async active-low reset
//   start       load a, b and begin; aborts any operation in flight
//   a, b        .xxx fractions (WIDTH)
//   p           full product (2*WIDTH), valid while ready
//   pn, sh      product normalized to WIDTH bits, sh=1 when shifted left by one
//   sticky      OR of product bits below pn
//   busy        iterating
//   ready       result valid, held until the next start
module fraction_multiplier_seq
  import fraction_multiplier_seq_pkg::*;
#(
  parameter int WIDTH = FRAC_W
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p,
  output logic [WIDTH-1:0]   pn,
  output logic               sh,
  output logic               sticky,
  output logic               busy,
  output logic               ready
);

  localparam int ITER  = iter_of(WIDTH);
  localparam int CNT_W = cnt_w_of(ITER);

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]   a_q,     a_d;
  logic [WIDTH+1:0]   a3_q,    a3_d;
  // Low half starts as the multiplier and is consumed two bits per step;
  // the accumulating product shifts in from the top.
  logic [2*WIDTH-1:0] p_q,     p_d;

  logic [WIDTH+1:0]   pp;
  logic [WIDTH+1:0]   sum;

  mul_radix4_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
    .a   (a_q),
    .a3  (a3_q),
    .dig (p_q[1:0]),
    .pp  (pp)
  );

  // Upper accumulator stays below 4*A, so WIDTH+2 bits hold the sum exactly.
  assign sum = {2'b00, p_q[2*WIDTH-1:WIDTH]} + pp;

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    a3_d    = a3_q;
    p_d     = p_q;
    if (start) begin
      state_d = S_RUN;
      ready_d = 1'b0;
      cnt_d   = '0;
      a_d     = a;
      a3_d    = {2'b00, a} + {1'b0, a, 1'b0};
      p_d     = {{WIDTH{1'b0}}, b};
    end else if (state_q == S_RUN) begin
      p_d   = {sum, p_q[WIDTH-1:2]};
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(ITER - 1)) begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      a3_q    <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      a3_q    <= a3_d;
      p_q     <= p_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign ready  = ready_q;
  assign p      = p_q;
  assign sh     = ~p[2*WIDTH-1];
  assign pn     = p[2*WIDTH-1] ? p[2*WIDTH-1:WIDTH] : p[2*WIDTH-2:WIDTH-1];
  assign sticky = p[2*WIDTH-1] ? |p[WIDTH-1:0] : |p[WIDTH-2:0];

endmodule
